stepper_phase_decoder: RTL
==========================

STEPPER_PHASE_DECODER -- requirements
Module: stepper_phase_decoder

Interface
REQ-001 The module SHALL have parameter FILTER_CYCLES, default 4, the number of consecutive cycles (range 1..15) a synchronized pattern must stay stable before it is accepted.
REQ-002 The module SHALL have parameter INTERVAL_WIDTH, default 16, the width of the step-interval counter.
REQ-003 The module SHALL have port clk, input, 1 bit, the single clock.
REQ-004 The module SHALL have port reset, input, 1 bit, a synchronous, active-high reset.
REQ-005 The module SHALL have port stepper_signals, input, 4 bits, the coil drive pattern, asynchronous to clk.
REQ-006 The module SHALL have port clear_error, input, 1 bit, which clears the sticky error.
REQ-007 The module SHALL have port position, output, 8 bits, the half-step position count (two's complement, wrapping).
REQ-008 The module SHALL have port step_pulse, output, 1 bit, high for one cycle per accepted step.
REQ-009 The module SHALL have port dir, output, 1 bit, where 1 means clockwise (index increasing) for the last step.
REQ-010 The module SHALL have port step_interval, output, INTERVAL_WIDTH bits, the cycles between the last two accepted steps.
REQ-011 The module SHALL have port error, output, 1 bit, a sticky flag for an illegal pattern or transition.
REQ-012 The module SHALL have port error_count, output, 8 bits, a saturating count of error events.
REQ-013 The module SHALL have port locked, output, 1 bit, high while a valid reference phase is held.

Function
REQ-014 The half-step phase table SHALL be, for index 0..7: 0001, 0011, 0010, 0110, 0100, 1100, 1000, 1001; 0000 is IDLE; every other pattern is ILLEGAL.
REQ-015 stepper_signals SHALL pass through a 2-flop synchronizer, then through the stability filter, before being decoded.
REQ-016 The filter SHALL accept a pattern after it has been seen unchanged for FILTER_CYCLES consecutive cycles; any change restarts the count, and an accepted pattern is not re-accepted.
REQ-017 The FSM SHALL have two states, UNLOCKED (the reset state) and LOCKED.
REQ-018 In UNLOCKED, an accepted table pattern SHALL load the reference index and move to LOCKED, with no step and no position change.
REQ-019 In UNLOCKED, accepted IDLE SHALL be ignored.
REQ-020 In LOCKED, for an accepted table pattern, delta = (new - ref) mod 8 SHALL give:
  - delta 1: position +1, dir=1
  - delta 7: position -1, dir=0
  - delta 2: position +2, dir=1
  - delta 6: position -2, dir=0
  - delta 3, 4 or 5: error event, reference updated, no position change, no step_pulse
  - delta 0: no action
REQ-021 For deltas 1, 2, 6 and 7, step_pulse SHALL assert for exactly one cycle and the reference SHALL be updated.
REQ-022 In LOCKED, accepted IDLE SHALL hold the reference and position and stay LOCKED (de-energized coils hold position).
REQ-023 An accepted ILLEGAL pattern in either state SHALL raise an error event and move to UNLOCKED, with position held.
REQ-024 On an error event, error SHALL be set and error_count SHALL increment, saturating at 255.
REQ-025 clear_error SHALL clear error only, not error_count; if an error event occurs in the same cycle, the event wins.
REQ-026 position SHALL wrap modulo 256 (127+1 gives -128; 0-2 gives 254 unsigned).
REQ-027 The interval counter SHALL increment every cycle and saturate at 2^INTERVAL_WIDTH-1.
REQ-028 On a step, step_interval SHALL load the counter value and the counter SHALL reset to 1, in the same cycle.
REQ-029 Latency from a stepper_signals change to its step_pulse, position, dir and step_interval update SHALL be 2 + FILTER_CYCLES + 1 clock edges; the outputs are registered.

Reset
REQ-030 While reset is high, every register SHALL clear at the next clk edge: state=UNLOCKED, position=0, step_pulse=0, dir=0, step_interval=0, interval counter=0, error=0, error_count=0, locked=0, synchronizer and filter cleared with no accepted pattern.
REQ-031 Reset asserted mid-filter or mid-step SHALL discard the pending pattern and suppress any step_pulse.

Structure
REQ-032 Package stepper_pkg SHALL hold the phase-table constant, the IDLE pattern, the state enum and the phase-index width.
REQ-033 One sub-module, signal_stable_filter (4-bit synchronizer plus stability counter, FILTER_CYCLES parameter), SHALL provide accepted_valid and accepted_pattern.

Verification
REQ-034 Reset, then 0001 held, then 0011 held 10 cycles -> locked=1, one step_pulse 7 cycles after the change, position=1, dir=1.
REQ-035 Locked at 0001, apply 0010 -> position=+2, dir=1; apply 0001 -> position=0, dir=0.
REQ-036 A 2-cycle glitch 0011 inside a stable 0001 -> no step_pulse, position unchanged.
REQ-037 Locked at 0001, apply 0100 (delta 4) -> error=1, error_count=1, position unchanged, locked=1; clear_error -> error=0, error_count=1.
REQ-038 Apply 1111 -> error=1, locked=0; then 0001 -> locked=1 with no step; stepping from position 127 by +1 -> position=128 (0x80).
REQ-039 Two steps 50 cycles apart -> step_interval=50; no step for 70000 cycles -> counter saturates, next step_interval=65535.

Source files
------------

// File: rtl/stepper_pkg.sv
// Shared definitions for the stepper phase decoder: the half-step phase table,
// the FSM state type and the pattern decode helper.
package stepper_pkg;

  localparam int unsigned PHASE_IDX_W = 3;
  localparam int unsigned PATTERN_W   = 4;
  localparam int unsigned NUM_PHASES  = 8;

  localparam logic [PATTERN_W-1:0] IDLE_PATTERN = 4'b0000;

  // Entry i holds the coil pattern for half-step index i.
  localparam logic [NUM_PHASES-1:0][PATTERN_W-1:0] PHASE_TABLE = {
    4'b1001, 4'b1000, 4'b1100, 4'b0100, 4'b0110, 4'b0010, 4'b0011, 4'b0001
  };

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } state_e;

  typedef struct packed {
    logic                   is_phase;
    logic                   is_idle;
    logic [PHASE_IDX_W-1:0] idx;
  } phase_decode_t;

  function automatic phase_decode_t decode_phase(input logic [PATTERN_W-1:0] pattern);
    phase_decode_t d;
    d         = '0;
    d.is_idle = (pattern == IDLE_PATTERN);
    for (int unsigned i = 0; i < NUM_PHASES; i++) begin
      if (PHASE_TABLE[i] == pattern) begin
        d.is_phase = 1'b1;
        d.idx      = PHASE_IDX_W'(i);
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/signal_stable_filter.sv
// Two-flop synchronizer followed by a stability filter: a pattern is accepted
// once after it has been seen unchanged for FILTER_CYCLES consecutive cycles.
module signal_stable_filter
  import stepper_pkg::*;
#(
  parameter int unsigned FILTER_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [PATTERN_W-1:0] raw_signals,
  output logic                 accepted_valid,
  output logic [PATTERN_W-1:0] accepted_pattern
);

  localparam int unsigned CNT_W = 4;

  logic [PATTERN_W-1:0] sync1_q, sync2_q, cand_q, pattern_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [CNT_W-1:0]     cnt_next;
  logic                 done_q;
  logic                 valid_q;

  assign cnt_next = cnt_q + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      cand_q    <= '0;
      pattern_q <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      sync1_q <= raw_signals;
      sync2_q <= sync1_q;
      valid_q <= 1'b0;
      if (sync2_q != cand_q) begin
        // New candidate: this cycle counts as its first sighting.
        cand_q <= sync2_q;
        cnt_q  <= CNT_W'(1);
        done_q <= (FILTER_CYCLES == 1);
        if (FILTER_CYCLES == 1) begin
          valid_q   <= 1'b1;
          pattern_q <= sync2_q;
        end
      end else if (!done_q) begin
        cnt_q <= cnt_next;
        if (cnt_next == CNT_W'(FILTER_CYCLES)) begin
          valid_q   <= 1'b1;
          done_q    <= 1'b1;
          pattern_q <= cand_q;
        end
      end
    end
  end

  assign accepted_valid   = valid_q;
  assign accepted_pattern = pattern_q;

endmodule

// File: rtl/stepper_phase_decoder.sv
// Decodes filtered half-step coil patterns into position, direction, step
// timing and error status relative to a locked reference phase.
module stepper_phase_decoder
  import stepper_pkg::*;
#(
  parameter int unsigned FILTER_CYCLES  = 4,
  parameter int unsigned INTERVAL_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [3:0]                stepper_signals,
  input  logic                      clear_error,
  output logic [7:0]                position,
  output logic                      step_pulse,
  output logic                      dir,
  output logic [INTERVAL_WIDTH-1:0] step_interval,
  output logic                      error,
  output logic [7:0]                error_count,
  output logic                      locked
);

  logic                      acc_valid;
  logic [PATTERN_W-1:0]      acc_pattern;
  phase_decode_t             dec_c;
  logic [PHASE_IDX_W-1:0]    delta_c;
  logic                      err_event_c, step_c, step_dir_c;
  logic [7:0]                step_delta_c;

  state_e                    state_q;
  logic [PHASE_IDX_W-1:0]    ref_q;
  logic [7:0]                position_q, error_count_q;
  logic                      step_pulse_q, dir_q, error_q, locked_q;
  logic [INTERVAL_WIDTH-1:0] interval_cnt_q, step_interval_q;

  signal_stable_filter #(
    .FILTER_CYCLES(FILTER_CYCLES)
  ) u_filter (
    .clk             (clk),
    .reset           (reset),
    .raw_signals     (stepper_signals),
    .accepted_valid  (acc_valid),
    .accepted_pattern(acc_pattern)
  );

  assign dec_c   = decode_phase(acc_pattern);
  assign delta_c = dec_c.idx - ref_q;

  // Classify the accepted pattern into step / error events.
  always_comb begin
    err_event_c  = 1'b0;
    step_c       = 1'b0;
    step_dir_c   = 1'b0;
    step_delta_c = '0;
    if (acc_valid) begin
      if (!dec_c.is_phase && !dec_c.is_idle) begin
        err_event_c = 1'b1;
      end else if (dec_c.is_phase && state_q == ST_LOCKED) begin
        case (delta_c)
          3'd1: begin step_c = 1'b1; step_dir_c = 1'b1; step_delta_c = 8'd1;   end
          3'd2: begin step_c = 1'b1; step_dir_c = 1'b1; step_delta_c = 8'd2;   end
          3'd6: begin step_c = 1'b1; step_dir_c = 1'b0; step_delta_c = 8'hFE; end
          3'd7: begin step_c = 1'b1; step_dir_c = 1'b0; step_delta_c = 8'hFF; end
          3'd3, 3'd4, 3'd5: err_event_c = 1'b1;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_UNLOCKED;
      ref_q           <= '0;
      position_q      <= '0;
      step_pulse_q    <= 1'b0;
      dir_q           <= 1'b0;
      step_interval_q <= '0;
      interval_cnt_q  <= '0;
      error_q         <= 1'b0;
      error_count_q   <= '0;
      locked_q        <= 1'b0;
    end else begin
      step_pulse_q <= step_c;
      if (acc_valid) begin
        if (!dec_c.is_phase && !dec_c.is_idle) begin
          state_q  <= ST_UNLOCKED;
          locked_q <= 1'b0;
        end else if (dec_c.is_phase) begin
          state_q  <= ST_LOCKED;
          locked_q <= 1'b1;
          ref_q    <= dec_c.idx;
        end
      end
      if (step_c) begin
        position_q      <= position_q + step_delta_c;
        dir_q           <= step_dir_c;
        step_interval_q <= interval_cnt_q;
        interval_cnt_q  <= INTERVAL_WIDTH'(1);
      end else if (interval_cnt_q != '1) begin
        interval_cnt_q <= interval_cnt_q + INTERVAL_WIDTH'(1);
      end
      // An error event in the same cycle takes priority over clear_error.
      if (err_event_c) begin
        error_q <= 1'b1;
        if (error_count_q != 8'hFF) error_count_q <= error_count_q + 8'd1;
      end else if (clear_error) begin
        error_q <= 1'b0;
      end
    end
  end

  assign position      = position_q;
  assign step_pulse    = step_pulse_q;
  assign dir           = dir_q;
  assign step_interval = step_interval_q;
  assign error         = error_q;
  assign error_count   = error_count_q;
  assign locked        = locked_q;

endmodule
